// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - sequential ALU with valid/ready handshake and optional iterative multiplier (macro SEQ_ALU_MUL_EN)
module seq_alu #(
    parameter int WIDTH = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             InValid,
    output logic             InReady,
    input  logic [3:0]       Opcode,
    input  logic [WIDTH-1:0] OperandA,
    input  logic [WIDTH-1:0] OperandB,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] Result,
    output logic             Carry,
    output logic             Overflow,
    output logic             Zero,
    output logic             Negative,
    output logic             Illegal,
    output logic             Busy
);

    localparam int H = WIDTH / 2;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] DONE = 2'd2;
`ifdef SEQ_ALU_MUL_EN
    localparam logic [1:0] EXEC = 2'd1;
`endif

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_NOT  = 4'h5;
    localparam logic [3:0] OP_SETH = 4'h6;
    localparam logic [3:0] OP_SETL = 4'h7;
    localparam logic [3:0] OP_EQ   = 4'h8;
    localparam logic [3:0] OP_LT   = 4'h9;
    localparam logic [3:0] OP_GT   = 4'hA;
`ifdef SEQ_ALU_MUL_EN
    localparam logic [3:0] OP_MUL  = 4'hB;
`endif

    generate
        if (WIDTH < 8 || (WIDTH % 2) != 0) begin : g_width_check
            $error("seq_alu: WIDTH must be even and at least 8");
        end
    endgenerate

    logic [1:0]       state;
    logic             accept;
    logic [WIDTH:0]   add_ext;
    logic [WIDTH:0]   sub_ext;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;
    logic             alu_ill;

    assign InReady  = (state == IDLE) || ((state == DONE) && OutReady);
    assign accept   = InValid && InReady;
    assign OutValid = (state == DONE);

`ifdef SEQ_ALU_MUL_EN
    localparam int CW = $clog2(WIDTH + 1);

    // Shift-add multiplier: hi accumulates partial sums, lo starts as the
    // multiplier and is shifted out one bit per iteration, so after WIDTH
    // iterations {hi, lo} holds the full 2*WIDTH product.
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] prod_hi;
    logic [WIDTH-1:0] prod_lo;
    logic [WIDTH:0]   step_sum;

    // One multiplier step: conditionally add the multiplicand into the high half
    always_comb begin
        step_sum = {1'b0, prod_hi} + (prod_lo[0] ? {1'b0, mcand} : '0);
    end

    // Busy covers the WIDTH iteration cycles, not the final flag-latch cycle
    assign Busy = (state == EXEC) && (cnt != CW'(WIDTH));
`else
    assign Busy = 1'b0;
`endif

    // Single-cycle datapath evaluated on the incoming operands
    always_comb begin
        add_ext = {1'b0, OperandA} + {1'b0, OperandB};
        sub_ext = {1'b0, OperandA} - {1'b0, OperandB};
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_ill = 1'b0;
        case (Opcode)
            OP_ADD: begin
                alu_res = add_ext[WIDTH-1:0];
                alu_c   = add_ext[WIDTH];
                alu_v   = (OperandA[WIDTH-1] == OperandB[WIDTH-1]) &&
                          (add_ext[WIDTH-1] != OperandA[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = sub_ext[WIDTH-1:0];
                alu_c   = sub_ext[WIDTH];
                alu_v   = (OperandA[WIDTH-1] != OperandB[WIDTH-1]) &&
                          (sub_ext[WIDTH-1] != OperandA[WIDTH-1]);
            end
            OP_AND:  alu_res = OperandA & OperandB;
            OP_OR:   alu_res = OperandA | OperandB;
            OP_XOR:  alu_res = OperandA ^ OperandB;
            OP_NOT:  alu_res = ~OperandA;
            OP_SETH: alu_res = {OperandA[H-1:0], OperandB[H-1:0]};
            OP_SETL: alu_res = {OperandB[WIDTH-1:H], OperandA[H-1:0]};
            OP_EQ:   alu_res = {{(WIDTH-1){1'b0}}, OperandA == OperandB};
            OP_LT:   alu_res = {{(WIDTH-1){1'b0}}, OperandA <  OperandB};
            OP_GT:   alu_res = {{(WIDTH-1){1'b0}}, OperandA >  OperandB};
            default: alu_ill = 1'b1;
        endcase
    end

    // Control FSM plus result/flag registers; result regs only change when a
    // new result is loaded, so they hold steady under backpressure
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state    <= IDLE;
            Result   <= '0;
            Carry    <= 1'b0;
            Overflow <= 1'b0;
            Zero     <= 1'b0;
            Negative <= 1'b0;
            Illegal  <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
            cnt      <= '0;
            mcand    <= '0;
            prod_hi  <= '0;
            prod_lo  <= '0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
`ifdef SEQ_ALU_MUL_EN
                        if (Opcode == OP_MUL) begin
                            state   <= EXEC;
                            cnt     <= '0;
                            mcand   <= OperandA;
                            prod_hi <= '0;
                            prod_lo <= OperandB;
                        end else
`endif
                        begin
                            state    <= DONE;
                            Result   <= alu_res;
                            Carry    <= alu_c;
                            Overflow <= alu_v;
                            Zero     <= (alu_res == '0);
                            Negative <= alu_res[WIDTH-1];
                            Illegal  <= alu_ill;
                        end
                    end else if (state == DONE && OutReady) begin
                        state <= IDLE;
                    end
                end
`ifdef SEQ_ALU_MUL_EN
                EXEC: begin
                    if (cnt == CW'(WIDTH)) begin
                        state    <= DONE;
                        Result   <= prod_lo;
                        Carry    <= 1'b0;
                        Overflow <= (prod_hi != '0);
                        Zero     <= (prod_lo == '0);
                        Negative <= prod_lo[WIDTH-1];
                        Illegal  <= 1'b0;
                    end else begin
                        cnt     <= cnt + CW'(1);
                        prod_hi <= step_sum[WIDTH:1];
                        prod_lo <= {step_sum[0], prod_lo[WIDTH-1:1]};
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - scoreboard testbench for seq_alu (honours SEQ_ALU_MUL_EN)
module tb_seq_alu;

    localparam int W = 16;

    logic         Clock = 1'b0;
    logic         Reset;
    logic         InValid;
    logic         InReady;
    logic [3:0]   Opcode;
    logic [W-1:0] OperandA;
    logic [W-1:0] OperandB;
    logic         OutValid;
    logic         OutReady;
    logic [W-1:0] Result;
    logic         Carry;
    logic         Overflow;
    logic         Zero;
    logic         Negative;
    logic         Illegal;
    logic         Busy;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [W+4:0] exp_q[$];

    seq_alu #(.WIDTH(W)) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .InValid  (InValid),
        .InReady  (InReady),
        .Opcode   (Opcode),
        .OperandA (OperandA),
        .OperandB (OperandB),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .Result   (Result),
        .Carry    (Carry),
        .Overflow (Overflow),
        .Zero     (Zero),
        .Negative (Negative),
        .Illegal  (Illegal),
        .Busy     (Busy)
    );

    always #5 Clock = ~Clock;

    // Expected entry layout: {result, carry, overflow, zero, negative, illegal}
    function automatic logic [W+4:0] pk(input logic [W-1:0] r, input logic c,
                                        input logic v, input logic z,
                                        input logic n, input logic i);
        return {r, c, v, z, n, i};
    endfunction

    task automatic check(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
        end
    endtask

    // Monitor: every completed handshake pops one expectation
    always @(negedge Clock) begin
        if (!Reset && OutValid && OutReady) begin
            logic [W+4:0] got;
            logic [W+4:0] want;
            got = {Result, Carry, Overflow, Zero, Negative, Illegal};
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL result_unexpected: got 0x%0h expected none", got);
            end else begin
                want = exp_q.pop_front();
                if (got != want) begin
                    n_fail++;
                    $display("FAIL result: got 0x%0h expected 0x%0h", got, want);
                end
            end
        end
    end

    // Present a request and return 1ns after the edge that accepted it
    task automatic issue(input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b);
        bit ok;
        InValid  = 1'b1;
        Opcode   = op;
        OperandA = a;
        OperandB = b;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge Clock);
            if (InReady) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge Clock);
        #1;
        InValid = 1'b0;
        if (!ok) begin
            n_cmp++;
            n_fail++;
            $display("FAIL accept_timeout: got no accept expected accept op 0x%0h", op);
        end
    endtask

    task automatic op_exp(input logic [3:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W+4:0] e);
        exp_q.push_back(e);
        issue(op, a, b);
    endtask

    initial begin
        int k;
        int busy_n;
        int rdy_bad;
        int ov_n;

        Reset    = 1'b1;
        InValid  = 1'b0;
        Opcode   = 4'h0;
        OperandA = '0;
        OperandB = '0;
        OutReady = 1'b1;

        #1;
        check("reset_result", Result, 0);
        check("reset_flags", {Carry, Overflow, Zero, Negative, Illegal}, 0);
        check("reset_outvalid", OutValid, 0);
        check("reset_busy", Busy, 0);
        repeat (3) @(posedge Clock);
        #1;
        Reset = 1'b0;
        @(posedge Clock);
        #1;
        check("inready_after_reset", InReady, 1);

        // ADD carry/zero corner, with one-edge latency check
        op_exp(4'h0, 16'hFFFF, 16'h0001, pk(16'h0000, 1, 0, 1, 0, 0));
        check("add_latency_outvalid", OutValid, 1);
        op_exp(4'h1, 16'h8000, 16'h0001, pk(16'h7FFF, 0, 1, 0, 0, 0));
        op_exp(4'h1, 16'h0003, 16'h0005, pk(16'hFFFE, 1, 0, 0, 1, 0));
        op_exp(4'h2, 16'hF0F0, 16'h0FF0, pk(16'h00F0, 0, 0, 0, 0, 0));
        op_exp(4'h3, 16'hF0F0, 16'h0FF0, pk(16'hFFF0, 0, 0, 0, 1, 0));
        op_exp(4'h5, 16'h00FF, 16'h1234, pk(16'hFF00, 0, 0, 0, 1, 0));
        op_exp(4'h6, 16'h12AB, 16'h34CD, pk(16'hABCD, 0, 0, 0, 1, 0));
        op_exp(4'h7, 16'h12AB, 16'h34CD, pk(16'h34AB, 0, 0, 0, 0, 0));
        op_exp(4'h8, 16'h0005, 16'h0005, pk(16'h0001, 0, 0, 0, 0, 0));
        op_exp(4'h9, 16'h0003, 16'h0005, pk(16'h0001, 0, 0, 0, 0, 0));
        op_exp(4'hA, 16'h0003, 16'h0005, pk(16'h0000, 0, 0, 1, 0, 0));
        op_exp(4'hF, 16'h1234, 16'h5678, pk(16'h0000, 0, 0, 1, 0, 1));
        check("illegal_latency_outvalid", OutValid, 1);

`ifdef SEQ_ALU_MUL_EN
        op_exp(4'hB, 16'h0100, 16'h0100, pk(16'h0000, 0, 1, 1, 0, 0));
        k = 0;
        busy_n = 0;
        rdy_bad = 0;
        if (Busy) busy_n++;
        if (InReady) rdy_bad++;
        while (!OutValid && k < 40) begin
            @(posedge Clock);
            #1;
            k++;
            if (!OutValid) begin
                if (Busy) busy_n++;
                if (InReady) rdy_bad++;
            end
        end
        check("mul_latency_edges", k, 17);
        check("mul_busy_cycles", busy_n, 16);
        check("mul_inready_low", rdy_bad, 0);
        op_exp(4'hB, 16'h0012, 16'h0034, pk(16'h03A8, 0, 0, 0, 0, 0));
`else
        op_exp(4'hB, 16'h0100, 16'h0100, pk(16'h0000, 0, 0, 1, 0, 1));
        check("mul_disabled_latency", OutValid, 1);
        check("mul_disabled_busy", Busy, 0);
        op_exp(4'hB, 16'h0012, 16'h0034, pk(16'h0000, 0, 0, 1, 0, 1));
`endif
        repeat (25) @(posedge Clock);
        #1;

        // Backpressure: XOR result held for 3 cycles while a request waits
        OutReady = 1'b0;
        op_exp(4'h4, 16'hF0F0, 16'h0FF0, pk(16'hFF00, 0, 0, 0, 1, 0));
        InValid  = 1'b1;
        Opcode   = 4'h0;
        OperandA = 16'h0001;
        OperandB = 16'h0002;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clock);
            check("bp_outvalid", OutValid, 1);
            check("bp_result_held", Result, 16'hFF00);
            check("bp_no_accept", InReady, 0);
        end
        @(posedge Clock);
        #1;
        OutReady = 1'b1;
        exp_q.push_back(pk(16'h0003, 0, 0, 0, 0, 0));
        @(posedge Clock);
        #1;
        check("b2b_outvalid_0", OutValid, 1);
        OperandA = 16'h7FFF;
        OperandB = 16'h0001;
        exp_q.push_back(pk(16'h8000, 0, 1, 0, 1, 0));
        @(posedge Clock);
        #1;
        check("b2b_outvalid_1", OutValid, 1);
        OperandA = 16'h1234;
        OperandB = 16'h1111;
        exp_q.push_back(pk(16'h2345, 0, 0, 0, 0, 0));
        @(posedge Clock);
        #1;
        check("b2b_outvalid_2", OutValid, 1);
        OperandA = 16'h8000;
        OperandB = 16'h8000;
        exp_q.push_back(pk(16'h0000, 1, 1, 1, 0, 0));
        @(posedge Clock);
        #1;
        check("b2b_outvalid_3", OutValid, 1);
        InValid = 1'b0;
        repeat (3) @(posedge Clock);
        #1;

        // Reset in the middle of a MUL: no result may ever appear for it
        OutReady = 1'b0;
        issue(4'hB, 16'h0100, 16'h0100);
        repeat (5) @(posedge Clock);
        #2;
`ifdef SEQ_ALU_MUL_EN
        check("mid_mul_busy", Busy, 1);
`else
        check("mid_mul_pending", OutValid, 1);
`endif
        Reset = 1'b1;
        #1;
        check("async_reset_result", Result, 0);
        check("async_reset_flags", {Carry, Overflow, Zero, Negative, Illegal}, 0);
        check("async_reset_outvalid", OutValid, 0);
        check("async_reset_busy", Busy, 0);
        @(posedge Clock);
        #1;
        Reset = 1'b0;
        OutReady = 1'b1;
        @(posedge Clock);
        #1;
        check("inready_after_release", InReady, 1);
        ov_n = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge Clock);
            #1;
            if (OutValid) ov_n++;
        end
        check("aborted_mul_no_result", ov_n, 0);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 16, datapath width; legal values are even and at least 8.
REQ-002 SHALL have port Clock, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port Reset, input, 1 bit, asynchronous active-high reset.
REQ-004 SHALL have port InValid, input, 1 bit, operation request present.
REQ-005 SHALL have port InReady, output, 1 bit, block accepts a request this cycle.
REQ-006 SHALL have port Opcode, input, 4 bits, operation select.
REQ-007 SHALL have ports OperandA and OperandB, input, WIDTH bits each, source operands.
REQ-008 SHALL have port OutValid, output, 1 bit, result registers hold a completed result.
REQ-009 SHALL have port OutReady, input, 1 bit, consumer takes the result this cycle.
REQ-010 SHALL have port Result, output, WIDTH bits, registered result.
REQ-011 SHALL have ports Carry, Overflow, Zero, Negative and Illegal, output, 1 bit each, registered status flags.
REQ-012 SHALL have port Busy, output, 1 bit, high while a multi-cycle operation is executing.

Function
REQ-013 SHALL accept a request on a Clock edge where InValid and InReady are both high; operands and opcode are captured at that edge.
REQ-014 SHALL use states IDLE, EXEC and DONE.
- IDLE: single-cycle opcode goes to DONE; MUL goes to EXEC.
- EXEC: goes to DONE after WIDTH iterations.
- DONE: stays in DONE until OutReady is high.
REQ-015 SHALL drive InReady = (state==IDLE) or (state==DONE and OutReady).
REQ-016 SHALL, in DONE with OutReady high and a new request accepted, return a single-cycle result on the next edge, giving one result per cycle.
REQ-017 SHALL, in DONE with OutReady high and no new request accepted, return to IDLE.
REQ-018 SHALL drive OutValid high exactly while in DONE.
REQ-019 SHALL hold Result and all flags stable while OutValid is high and OutReady is low.
REQ-020 SHALL implement this opcode map (WIDTH=W, H=W/2):
- 0 ADD: A+B
- 1 SUB: A-B
- 2 AND, 3 OR, 4 XOR: bitwise A op B
- 5 NOT: ~A
- 6 SETH: {A[H-1:0], B[H-1:0]}
- 7 SETL: {B[W-1:H], A[H-1:0]}
- 8 EQ, 9 LT, A GT: unsigned compare; Result is 1 or 0, zero-extended
- B MUL: low W bits of unsigned A*B
REQ-021 SHALL give single-cycle opcodes a latency of 1: OutValid rises on the edge after acceptance.
REQ-022 SHALL compute MUL by iterative shift-add, one bit per cycle.
REQ-023 SHALL hold Busy high for WIDTH cycles during MUL, with OutValid rising WIDTH+1 edges after acceptance.
REQ-024 SHALL set Carry as follows:
- ADD: carry out.
- SUB: borrow, i.e. 1 when A<B unsigned.
- All other opcodes: 0.
REQ-025 SHALL set Overflow as follows:
- ADD/SUB: signed overflow.
- MUL: 1 when the upper W bits of the product are nonzero.
- All other opcodes: 0.
REQ-026 SHALL set Zero = (Result==0) and Negative = Result[W-1] for every opcode.
REQ-027 SHALL treat opcodes C-F as illegal: Result 0, Illegal 1, Zero 1, other flags 0, latency 1.
REQ-028 SHALL set Illegal to 0 for every legal opcode.

Reset
REQ-029 SHALL, while Reset is high, immediately force the following regardless of Clock:
- state IDLE, iteration counter 0;
- Result 0, all flags 0;
- OutValid 0, Busy 0.
REQ-030 SHALL abort any in-flight MUL when reset is asserted and produce no result for it.
REQ-031 SHALL drive InReady high from the first edge after Reset deasserts.

Configuration
REQ-032 SHALL compile the multiplier (EXEC state, counter, shift-add datapath) only when macro SEQ_ALU_MUL_EN is defined.
REQ-033 SHALL, without SEQ_ALU_MUL_EN, treat opcode B as illegal per REQ-027 and hold Busy constant 0.

Verification (WIDTH=16)
REQ-034 SHALL cover ADD 0xFFFF+0x0001 -> Result 0x0000, Carry 1, Zero 1, Overflow 0, OutValid one edge after accept.
REQ-035 SHALL cover SUB 0x8000-0x0001 -> Result 0x7FFF, Overflow 1, Carry 0, Negative 0.
REQ-036 SHALL cover MUL 0x0100*0x0100 with SEQ_ALU_MUL_EN -> Result 0x0000, Overflow 1, Busy 16 cycles, InReady 0 until DONE, OutValid 17 edges after accept; without the macro -> Illegal 1 after 1 edge.
REQ-037 SHALL cover backpressure: OutReady low 3 cycles after XOR 0xF0F0^0x0FF0 -> Result 0xFF00 held, no accept; then 4 back-to-back ADDs -> 4 results on 4 consecutive edges.
REQ-038 SHALL cover Reset asserted mid-MUL (cycle 5) -> outputs 0 immediately, no result delivered, InReady 1 after release.
REQ-039 SHALL cover opcode 0xF, and SETH 0x12AB/0x34CD -> Illegal 1 with Result 0; and Result 0xABCD respectively.
